// File: rtl/leve_fetch_queue_if.sv
// leve_fetch_queue_if: AXI read address/data channel bundle between the fetch queue and instruction memory.
interface leve_fetch_queue_if #(parameter int XLEN = 32);
    logic            ARVALID;
    logic            ARREADY;
    logic [XLEN-1:0] ARADDR;
    logic            RVALID;
    logic            RREADY;
    logic [31:0]     RDATA;
    logic [1:0]      RRESP;
    modport master (output ARVALID, ARADDR, RREADY, input ARREADY, RVALID, RDATA, RRESP);
    modport slave  (input ARVALID, ARADDR, RREADY, output ARREADY, RVALID, RDATA, RRESP);
endinterface

// File: rtl/leve_fetch_queue.sv
// leve_fetch_queue: multi-outstanding AXI instruction prefetch queue with redirect flush and stale-response drop.
// Optional LEVE_FETCH_ERR_EN: tag entries with bus errors and halt fetch after an erroring beat.
module leve_fetch_queue #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 4,
    parameter int              MAX_OUTST = 2,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IPC_WE,
    input  logic [XLEN-1:0]  INEXT_PC,
    output logic             OVALID,
    input  logic             OREADY,
    output logic [XLEN-1:0]  OPC,
    output logic [31:0]      OINSTR,
    output logic             OERR,
    leve_fetch_queue_if.master axi
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] MAXO = CW'(MAX_OUTST);
    localparam logic [CW:0] DEP = (CW+1)'(DEPTH);
    localparam logic [XLEN-1:0] RST_PC = RESET_PC & ~XLEN'(3);

    logic [XLEN-1:0] mem_pc_q [DEPTH];
    logic [31:0]     mem_ins_q [DEPTH];
    logic            mem_err_q [DEPTH];
    logic [CW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d, inflight_q, inflight_d, drop_q, drop_d, count;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, push_pc_q, push_pc_d, araddr_q, araddr_d, tgt;
    logic            arvalid_q, arvalid_d, halt_q, halt_d;
    logic            beat, ar_issue, push, pop, err_beat;

`ifdef LEVE_FETCH_ERR_EN
    assign err_beat = axi.RRESP != 2'b00;
`else
    logic unused_rresp;
    assign unused_rresp = ^axi.RRESP;
    assign err_beat = 1'b0;
`endif

    assign count = wptr_q - rptr_q;
    assign tgt   = INEXT_PC & ~XLEN'(3);
    assign beat  = axi.RVALID & axi.RREADY;
    // Pending AR is already counted in inflight, so reservation covers it too.
    assign ar_issue = ~IPC_WE & ~halt_q & (~arvalid_q | axi.ARREADY) & (inflight_q < MAXO)
                    & (({1'b0, count} + {1'b0, inflight_q}) < DEP);
    assign pop  = OVALID & OREADY & ~IPC_WE;
    assign push = beat & ~IPC_WE & (drop_q == '0);

    always_comb begin
        inflight_d = inflight_q + CW'(ar_issue) - CW'(beat);
        drop_d     = IPC_WE ? inflight_d : (beat && drop_q != '0) ? drop_q - CW'(1) : drop_q;
        arvalid_d  = ar_issue | (arvalid_q & ~axi.ARREADY);
        araddr_d   = ar_issue ? fetch_pc_q : araddr_q;
        fetch_pc_d = IPC_WE ? tgt : ar_issue ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
        push_pc_d  = IPC_WE ? tgt : push ? push_pc_q + XLEN'(4) : push_pc_q;
        wptr_d     = IPC_WE ? '0 : wptr_q + CW'(push);
        rptr_d     = IPC_WE ? '0 : rptr_q + CW'(pop);
        halt_d     = IPC_WE ? 1'b0 : halt_q | (push & err_beat);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            arvalid_q  <= 1'b0;
            araddr_q   <= '0;
            fetch_pc_q <= RST_PC;
            push_pc_q  <= RST_PC;
            halt_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc_q[i]  <= '0;
                mem_ins_q[i] <= '0;
                mem_err_q[i] <= 1'b0;
            end
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            arvalid_q  <= arvalid_d;
            araddr_q   <= araddr_d;
            fetch_pc_q <= fetch_pc_d;
            push_pc_q  <= push_pc_d;
            halt_q     <= halt_d;
            if (push) begin
                mem_pc_q[wptr_q[AW-1:0]]  <= push_pc_q;
                mem_ins_q[wptr_q[AW-1:0]] <= axi.RDATA;
                mem_err_q[wptr_q[AW-1:0]] <= err_beat;
            end
        end
    end

    assign OVALID      = count != '0;
    assign OPC         = mem_pc_q[rptr_q[AW-1:0]];
    assign OINSTR      = mem_ins_q[rptr_q[AW-1:0]];
    assign OERR        = mem_err_q[rptr_q[AW-1:0]];
    assign axi.ARVALID = arvalid_q;
    assign axi.ARADDR  = araddr_q;
    assign axi.RREADY  = 1'b1;
endmodule

// File: tb/tb_leve_fetch_queue.sv
// tb_leve_fetch_queue: directed and randomized check of leve_fetch_queue against a queue-level reference model.
// Build with LEVE_FETCH_ERR_EN defined to also cover the bus-error halt path.
module tb_leve_fetch_queue;
    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    typedef struct packed { logic [31:0] pc; logic [31:0] ins; logic err; } ent_t;
    typedef struct packed { logic [31:0] addr; int due; } req_t;

    logic        CLK = 0, RST = 1, IPC_WE = 0, OREADY = 0;
    logic [31:0] INEXT_PC = '0;
    logic        OVALID, OERR;
    logic [31:0] OPC, OINSTR;

    leve_fetch_queue_if #(.XLEN(32)) axi ();

    leve_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .MAX_OUTST(MAXO), .RESET_PC(32'h100)) dut (
        .CLK(CLK), .RST(RST), .IPC_WE(IPC_WE), .INEXT_PC(INEXT_PC),
        .OVALID(OVALID), .OREADY(OREADY), .OPC(OPC), .OINSTR(OINSTR), .OERR(OERR), .axi(axi));

    always #5 CLK = ~CLK;

    int n_chk = 0, n_fail = 0, cyc = 0;
    int ar_pct = 100, r_pct = 100, o_pct = 100, we_pct = 0, err_pct = 0, lat_min = 1, lat_var = 0;
    logic force_we = 0, force_rst = 1, chk_en = 0;
    logic [31:0] we_tgt = '0, err_addr = '1;
    req_t pend[$];
    logic [31:0] ar_log[$], pop_log[$];
    // Reference model: the queue is a plain list of entries, counters are plain ints.
    ent_t mq[$];
    int m_infl, m_drop;
    bit m_arv, m_halt;
    logic [31:0] m_araddr, m_fpc, m_ppc;

    function automatic logic [31:0] word_of(logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'h1234};
    endfunction

    function automatic logic [31:0] rand_tgt();
        case ($urandom_range(2))
            0: return $urandom;
            1: return 32'hFFFF_FFF0 + 32'($urandom_range(15));
            default: return 32'($urandom_range(255)) << 2;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_infl = 0; m_drop = 0; m_arv = 0; m_halt = 0;
        m_araddr = '0; m_fpc = 32'h100; m_ppc = 32'h100;
    endtask

    task automatic compare();
        chk("ARVALID", 32'(axi.ARVALID), 32'(m_arv));
        chk("ARADDR", axi.ARADDR, m_araddr);
        chk("RREADY", 32'(axi.RREADY), 32'd1);
        chk("OVALID", 32'(OVALID), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("OPC", OPC, mq[0].pc);
            chk("OINSTR", OINSTR, mq[0].ins);
            chk("OERR", 32'(OERR), 32'(mq[0].err));
        end
    endtask

    task automatic model_step();
        bit beat, issue, pop, err;
        int ninfl;
        if (RST) begin
            model_reset();
            return;
        end
        beat  = axi.RVALID;
        issue = !IPC_WE && !m_halt && (!m_arv || axi.ARREADY) && m_infl < MAXO && mq.size() + m_infl < DEPTH;
        pop   = mq.size() > 0 && OREADY;
        ninfl = m_infl + int'(issue) - int'(beat);
`ifdef LEVE_FETCH_ERR_EN
        err = axi.RRESP != 2'b00;
`else
        err = 0;
`endif
        if (IPC_WE) begin
            mq.delete();
            m_fpc = INEXT_PC & ~32'h3;
            m_ppc = m_fpc;
            m_drop = ninfl;
            m_halt = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (beat && m_drop > 0) m_drop--;
            else if (beat) begin
                mq.push_back('{m_ppc, axi.RDATA, err});
                m_ppc += 4;
                m_halt |= err;
            end
            if (issue) begin
                m_araddr = m_fpc;
                m_fpc += 4;
            end
        end
        m_arv = issue || (m_arv && !axi.ARREADY);
        m_infl = ninfl;
    endtask

    task automatic drive();
        RST      = force_rst;
        IPC_WE   = force_we || (!force_rst && $urandom_range(99) < we_pct);
        INEXT_PC = force_we ? we_tgt : rand_tgt();
        OREADY   = $urandom_range(99) < o_pct;
        axi.ARREADY = $urandom_range(99) < ar_pct;
        axi.RVALID  = !force_rst && pend.size() > 0 && pend[0].due <= cyc && $urandom_range(99) < r_pct;
        axi.RDATA   = $urandom;
        axi.RRESP   = 2'b00;
        if (axi.RVALID) begin
            axi.RDATA = word_of(pend[0].addr);
            if (pend[0].addr == err_addr || $urandom_range(99) < err_pct) axi.RRESP = 2'($urandom_range(3, 1));
        end
    endtask

    task automatic cycle();
        req_t r;
        @(posedge CLK);
        cyc++;
        #1 drive();
        @(negedge CLK);
        if (chk_en) compare();
        if (OVALID && OREADY && !IPC_WE && !RST) pop_log.push_back(OPC);
        if (RST) pend.delete();
        else begin
            if (axi.RVALID && axi.RREADY && pend.size() > 0) void'(pend.pop_front());
            if (axi.ARVALID && axi.ARREADY) begin
                ar_log.push_back(axi.ARADDR);
                r.addr = axi.ARADDR;
                r.due = cyc + lat_min + int'($urandom_range(lat_var));
                pend.push_back(r);
            end
        end
        model_step();
    endtask

    task automatic do_reset();
        force_rst = 1;
        cycle();
        cycle();
        force_rst = 0;
        ar_log.delete();
        pop_log.delete();
    endtask

    task automatic redirect(logic [31:0] t);
        force_we = 1;
        we_tgt = t;
        cycle();
        force_we = 0;
    endtask

    task automatic knobs(int a, int r, int o);
        ar_pct = a; r_pct = r; o_pct = o; we_pct = 0; err_pct = 0; lat_min = 1; lat_var = 0;
    endtask

    initial begin
        cycle();
        chk_en = 1;
        // Reset values and in-order streaming from RESET_PC.
        knobs(100, 100, 100);
        do_reset();
        chk("rst_ARVALID", 32'(axi.ARVALID), 32'd0);
        chk("rst_OVALID", 32'(OVALID), 32'd0);
        chk("rst_OERR", 32'(OERR), 32'd0);
        chk("rst_OPC", OPC, 32'd0);
        chk("rst_OINSTR", OINSTR, 32'd0);
        chk("rst_ARADDR", axi.ARADDR, 32'd0);
        chk("rst_RREADY", 32'(axi.RREADY), 32'd1);
        for (int i = 0; i < 40; i++) cycle();
        chk("A_ar_cnt", 32'(ar_log.size() >= 3), 32'd1);
        chk("A_ar0", ar_log[0], 32'h100);
        chk("A_ar1", ar_log[1], 32'h104);
        chk("A_ar2", ar_log[2], 32'h108);
        chk("A_pop_cnt", 32'(pop_log.size() >= 3), 32'd1);
        chk("A_pop0", pop_log[0], 32'h100);
        chk("A_pop2", pop_log[2], 32'h108);
        // Stalled consumer: exactly DEPTH requests, then one pop frees one slot.
        knobs(100, 100, 0);
        do_reset();
        for (int i = 0; i < 30; i++) cycle();
        chk("B_ar_cnt", 32'(ar_log.size()), 32'd4);
        chk("B_ovalid", 32'(OVALID), 32'd1);
        chk("B_arvalid", 32'(axi.ARVALID), 32'd0);
        chk("B_opc", OPC, 32'h100);
        o_pct = 100;
        cycle();
        o_pct = 0;
        for (int i = 0; i < 10; i++) cycle();
        chk("B_ar_cnt2", 32'(ar_log.size()), 32'd5);
        chk("B_pop_cnt", 32'(pop_log.size()), 32'd1);
        chk("B_ar4", ar_log[4], 32'h110);
        // Redirect while an AR is held by ARREADY=0.
        knobs(0, 100, 100);
        do_reset();
        redirect(32'h200);
        for (int i = 0; i < 3; i++) cycle();
        chk("C_arvalid", 32'(axi.ARVALID), 32'd1);
        chk("C_araddr", axi.ARADDR, 32'h200);
        redirect(32'h400);
        for (int i = 0; i < 3; i++) cycle();
        chk("C_hold", axi.ARADDR, 32'h200);
        ar_pct = 100;
        for (int i = 0; i < 40 && pop_log.size() == 0; i++) cycle();
        chk("C_pop0", pop_log[0], 32'h400);
        chk("C_ar0", ar_log[0], 32'h200);
        chk("C_ar1", ar_log[1], 32'h400);
        // Two in flight, redirect to an unaligned target.
        knobs(100, 0, 100);
        do_reset();
        for (int i = 0; i < 6; i++) cycle();
        chk("D_ar_cnt", 32'(ar_log.size()), 32'd2);
        redirect(32'h1002);
        r_pct = 100;
        for (int i = 0; i < 40 && pop_log.size() == 0; i++) cycle();
        chk("D_pop0", pop_log[0], 32'h1000);
        chk("D_ar2", ar_log[2], 32'h1000);
        // Redirect coinciding with an R beat and a pop.
        knobs(100, 0, 0);
        do_reset();
        for (int i = 0; i < 6; i++) cycle();
        r_pct = 100;
        cycle();
        o_pct = 100;
        redirect(32'h2000);
        chk("E_pre_ovalid", 32'(OVALID), 32'd1);
        cycle();
        chk("E_flush", 32'(OVALID), 32'd0);
        for (int i = 0; i < 40 && pop_log.size() == 0; i++) cycle();
        chk("E_pop0", pop_log[0], 32'h2000);
`ifdef LEVE_FETCH_ERR_EN
        begin
            int n;
            knobs(100, 100, 100);
            err_addr = 32'h108;
            do_reset();
            for (int i = 0; i < 40 && !(OVALID && OPC == 32'h108); i++) cycle();
            chk("F_err_pc", OPC, 32'h108);
            chk("F_oerr", 32'(OERR), 32'd1);
            n = ar_log.size();
            for (int i = 0; i < 20; i++) cycle();
            chk("F_halt", 32'(ar_log.size()), 32'(n));
            err_addr = '1;
            redirect(32'h0);
            for (int i = 0; i < 40 && ar_log.size() <= n; i++) cycle();
            chk("F_resume", ar_log[n], 32'h0);
        end
`endif
        // Randomized traffic with redirects, bus errors and mid-run resets.
        err_addr = '1;
        for (int b = 0; b < 20; b++) begin
            ar_pct = $urandom_range(100, 20);
            r_pct = $urandom_range(100, 20);
            o_pct = $urandom_range(100, 0);
            we_pct = $urandom_range(8, 1);
            err_pct = $urandom_range(10);
            lat_min = $urandom_range(4, 1);
            lat_var = $urandom_range(3);
            if (b % 5 == 0) do_reset();
            for (int i = 0; i < 200; i++) cycle();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
